// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one start/done memory port between the instruction-fetch
// path and the data load/store path. One transaction is in flight at a time.
// Data requests win over fetch unless data has already taken DATA_BURST_MAX
// grants in a row while fetch waited. A WAIT that outlasts TIMEOUT cycles is
// aborted and answered with zero data and bus_err.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_BURST_MAX = 4,
  parameter int TIMEOUT        = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  // fetch requester
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [31:0]           i_rdata,
  output logic                  i_ack,
  // data requester
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_ack,
  // completion status shared by both requesters
  output logic                  bus_err,
  // memory port
  output logic                  mem_start,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_done,
  output logic                  busy
);

  // Streak counter must be able to hold DATA_BURST_MAX itself.
  localparam int STREAK_W = $clog2(DATA_BURST_MAX + 1);
  localparam int TIMER_W  = $clog2(TIMEOUT) + 1;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_BURST_MAX);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_data_q, grant_data_d;   // 1: data owns the transaction
  logic [STREAK_W-1:0]   streak_q, streak_d;           // data grants since fetch last won
  logic [TIMER_W-1:0]    timer_q, timer_d;             // cycles spent in WAIT
  logic                  err_q, err_d;                 // current transaction timed out
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           i_rdata_q, i_rdata_d;
  logic [31:0]           d_rdata_q, d_rdata_d;

  // Scratch values produced by the next-state logic.
  logic                  take_data;
  logic                  resp_valid;
  logic [31:0]           resp_data;

  // Next-state, grant and completion logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    grant_data_d = grant_data_q;
    streak_d     = streak_q;
    timer_d      = timer_q;
    err_d        = err_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    take_data    = 1'b0;
    resp_valid   = 1'b0;
    resp_data    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          // Data wins unless fetch is also waiting and data used up its burst.
          take_data    = d_req && !(i_req && (streak_q == STREAK_MAX));
          grant_data_d = take_data;
          state_d      = S_ISSUE;
          if (take_data) begin
            streak_d    = (streak_q == STREAK_MAX) ? streak_q
                                                   : streak_q + STREAK_W'(1);
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            streak_d    = '0;
            mem_we_d    = 1'b0;
            mem_be_d    = 4'b1111;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
          end
        end
      end

      S_ISSUE: begin
        // mem_start is high this cycle; a done here is not a legal response.
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mem_done) begin
          resp_valid = 1'b1;
          resp_data  = mem_rdata;
          err_d      = 1'b0;
          state_d    = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          resp_valid = 1'b1;
          resp_data  = '0;
          err_d      = 1'b1;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Only the granted side's read-data register changes; both hold afterwards.
    if (resp_valid) begin
      if (grant_data_q) begin
        d_rdata_d = resp_data;
      end else begin
        i_rdata_d = resp_data;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (reset) begin
      // NOTE: the datapath registers are reset too, because they drive ports
      // that must read zero after reset, not just the control state.
      state_q      <= S_IDLE;
      grant_data_q <= 1'b0;
      streak_q     <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      streak_q     <= streak_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Strobes decoded from state; fields come straight from the holding registers.
  assign mem_start = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign i_ack     = (state_q == S_RESP) && !grant_data_q;
  assign d_ack     = (state_q == S_RESP) &&  grant_data_q;
  assign bus_err   = (state_q == S_RESP) &&  err_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
